// File: rtl/rdo_pkg.sv
// Shared types and helpers for the pixel-readout grant capture stage.
package rdo_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CLEAR    = 2'd1,
        WAIT_REL = 2'd2
    } cap_state_e;

    localparam int ADDR_W_DFLT = 4;
    localparam int TS_W_DFLT   = 8;
    localparam int HIT_W       = ADDR_W_DFLT + TS_W_DFLT;
    localparam int ERR_CNT_W   = 8;

    // True when exactly one bit of v is set.
    function automatic logic is_onehot(input logic [31:0] v);
        return (v != 32'h0) && ((v & (v - 32'd1)) == 32'h0);
    endfunction

    // Index of the highest set bit; only meaningful for a one-hot input.
    function automatic int onehot_idx(input logic [31:0] v);
        int idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/hit_grant_capture_if.sv
// Hit-word stream from the capture stage to the serializer.
interface hit_grant_capture_if
    import rdo_pkg::*;
#(
    parameter int W = HIT_W
);
    logic [W-1:0] outData;
    logic         outValid;
    logic         outReady;

    modport master (output outData, output outValid, input outReady);
    modport slave  (input outData, input outValid, output outReady);
endinterface

// File: rtl/hit_fifo.sv
// Small show-ahead FIFO for hit words. Depth must be a power of two so the
// pointers wrap naturally.
module hit_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_en, rd_en;

    // Full deliberately ignores a same-cycle pop.
    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        wr_en    = push && !full;
        rd_en    = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage and pointer registers; contents are cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/hit_grant_capture.sv
// Captures the winning pixel from the asynchronous arbiter tree, timestamps
// it, clears the pixel's hit latch and waits for the grant to release.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a stable grant (one-hot push or multi-hot error)
// CLEAR    | driving pixClr = mask for CLR_CYC cycles
// WAIT_REL | waiting for the masked grant bits to drop, with timeout
module hit_grant_capture
    import rdo_pkg::*;
#(
    parameter int N_PIX      = 16,
    parameter int ADDR_W     = 4,
    parameter int TS_W       = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CLR_CYC    = 2,
    parameter int REL_TMO    = 15
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_PIX-1:0]            grant,
    output logic [N_PIX-1:0]            pixClr,
    hit_grant_capture_if.master         out_if,
    output logic [$clog2(FIFO_DEPTH):0] fifoCount,
    output logic                        busy,
    input  logic                        errClr,
    output logic                        errMulti,
    output logic                        errTmo,
    output logic [ERR_CNT_W-1:0]        errCnt
);
    localparam int WORD_W = ADDR_W + TS_W;
    localparam int CLR_W  = (CLR_CYC < 2) ? 1 : $clog2(CLR_CYC);
    localparam int TMO_W  = (REL_TMO < 1) ? 1 : $clog2(REL_TMO + 1);

    logic [N_PIX-1:0]     gs1_q, gs1_d, gs2_q, gs2_d, gp_q, gp_d;
    logic [TS_W-1:0]      ts_q, ts_d;
    cap_state_e           state_q, state_d;
    logic [N_PIX-1:0]     mask_q, mask_d;
    logic [N_PIX-1:0]     pix_clr_q, pix_clr_d;
    logic [CLR_W-1:0]     clr_cnt_q, clr_cnt_d;
    logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
    logic                 err_multi_q, err_multi_d;
    logic                 err_tmo_q, err_tmo_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic              stable, onehot, multi_evt, tmo_evt;
    logic              fifo_push, fifo_full, fifo_empty;
    logic [WORD_W-1:0] push_word, head_word;

    hit_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (push_word),
        .pop       (out_if.outReady),
        .head_data (head_word),
        .count     (fifoCount),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_if.outData  = head_word;
    assign out_if.outValid = !fifo_empty;
    assign pixClr          = pix_clr_q;
    assign busy            = (state_q != IDLE);
    assign errMulti        = err_multi_q;
    assign errTmo          = err_tmo_q;
    assign errCnt          = err_cnt_q;

    // Grant synchronizer, one-cycle delayed copy, free-running timestamp.
    always_comb begin
        gs1_d = grant;
        gs2_d = gs1_q;
        gp_d  = gs2_q;
        ts_d  = ts_q + TS_W'(1);
    end

    // Capture FSM: next state, mask, counters and the registered clear lines.
    always_comb begin
        stable    = (gs2_q == gp_q) && (gs2_q != '0);
        onehot    = is_onehot(32'(gs2_q));
        push_word = {ADDR_W'(onehot_idx(32'(gs2_q))), ts_q};
        fifo_push = 1'b0;
        multi_evt = 1'b0;
        tmo_evt   = 1'b0;
        state_d   = state_q;
        mask_d    = mask_q;
        clr_cnt_d = clr_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        case (state_q)
            IDLE: begin
                if (stable) begin
                    if (!onehot) begin
                        multi_evt = 1'b1;
                        mask_d    = gs2_q;
                        clr_cnt_d = CLR_W'(CLR_CYC - 1);
                        state_d   = CLEAR;
                    end else if (!fifo_full) begin
                        // Full FIFO: leave the pixel requesting, it retries.
                        fifo_push = 1'b1;
                        mask_d    = gs2_q;
                        clr_cnt_d = CLR_W'(CLR_CYC - 1);
                        state_d   = CLEAR;
                    end
                end
            end
            CLEAR: begin
                if (clr_cnt_q == '0) begin
                    tmo_cnt_d = TMO_W'(REL_TMO);
                    state_d   = WAIT_REL;
                end else begin
                    clr_cnt_d = clr_cnt_q - 1'b1;
                end
            end
            WAIT_REL: begin
                if ((gs2_q & mask_q) == '0) begin
                    state_d = IDLE;
                end else if (tmo_cnt_q == '0) begin
                    tmo_evt = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        pix_clr_d = (state_d == CLEAR) ? mask_d : '0;
    end

    // Sticky error flags and saturating event counter; errClr wins.
    always_comb begin
        err_multi_d = err_multi_q | multi_evt;
        err_tmo_d   = err_tmo_q | tmo_evt;
        err_cnt_d   = err_cnt_q;
        if ((multi_evt || tmo_evt) && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
        if (errClr) begin
            err_multi_d = 1'b0;
            err_tmo_d   = 1'b0;
            err_cnt_d   = '0;
        end
    end

    // All state registers; reset drops pixClr immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gs1_q       <= '0;
            gs2_q       <= '0;
            gp_q        <= '0;
            ts_q        <= '0;
            state_q     <= IDLE;
            mask_q      <= '0;
            pix_clr_q   <= '0;
            clr_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            err_multi_q <= 1'b0;
            err_tmo_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            gs1_q       <= gs1_d;
            gs2_q       <= gs2_d;
            gp_q        <= gp_d;
            ts_q        <= ts_d;
            state_q     <= state_d;
            mask_q      <= mask_d;
            pix_clr_q   <= pix_clr_d;
            clr_cnt_q   <= clr_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            err_multi_q <= err_multi_d;
            err_tmo_q   <= err_tmo_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

endmodule

// File: doc/hit_grant_capture.md
Name: hit_grant_capture

Overview:
- Synchronous stage directly downstream of the asynchronous mutual-exclusion arbiter tree in the pixel readout.
- Samples the tree's asynchronous one-hot grant bus and encodes the winning pixel address with a timestamp.
- Pulses that pixel's clear line so its request drops and the tree re-arbitrates, then waits for the grant to release.
- Buffers hit words in a small FIFO, read out through a valid/ready interface by the serializer.

Parameters:
N_PIX, 16, grant/clear lines, one per arbitrated pixel
ADDR_W, 4, address width; must equal ceil(log2(N_PIX))
TS_W, 8, timestamp counter width
FIFO_DEPTH, 4, hit-word buffer depth; power of two, at least 2
CLR_CYC, 2, clear pulse length in clk cycles; at least 1
REL_TMO, 15, cycles WAIT_REL waits for the grant to drop before flagging an error

Ports:
clk  in  1  readout clock
rst_n  in  1  reset, asynchronous, active-low
grant  in  N_PIX  asynchronous one-hot acks from arbiter tree
pixClr  out  N_PIX  per-pixel hit-latch clear, active-high
outData  out  ADDR_W+TS_W  hit word {addr, ts}; addr occupies the MSBs
outValid  out  1  FIFO non-empty
outReady  in  1  consumer accepts outData on a clk edge where outValid and outReady are both high
fifoCount  out  log2(FIFO_DEPTH)+1  occupancy
busy  out  1  FSM not in IDLE
errClr  in  1  synchronous clear of error flags and counter
errMulti  out  1  sticky: a stable multi-hot grant was seen
errTmo  out  1  sticky: release timeout
errCnt  out  8  saturating count of multi-hot and timeout events

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values: every output 0, all FIFO contents cleared, timestamp 0, state IDLE, synchronizers 0. A reset mid-operation drops pixClr immediately.
- Sampling pipeline:
  - grant passes through a 2-flop synchronizer: gS1, then gS2.
  - gP is gS2 delayed one cycle.
  - stable = (gS2 == gP) and gS2 != 0.
- Timestamp: free-running counter, increments every cycle, wraps 2^TS_W-1 -> 0.
- FSM states: IDLE, CLEAR, WAIT_REL.
- IDLE:
  - stable and one-hot and FIFO not full -> push {enc(gS2), ts}, latch mask = gS2, go to CLEAR.
  - stable and one-hot and FIFO full -> remain in IDLE, no push, no clear. The pixel holds its request, which provides backpressure. Nothing is lost.
  - stable and multi-hot -> no push; set errMulti; errCnt += 1; latch mask = gS2; go to CLEAR.
- CLEAR: pixClr = mask for exactly CLR_CYC cycles, then go to WAIT_REL. pixClr is 0 in every other state.
- WAIT_REL:
  - (gS2 & mask) == 0 -> go to IDLE.
  - After REL_TMO cycles with no release -> set errTmo, errCnt += 1, go to IDLE.
- errCnt saturates at 255. errClr has priority over any same-cycle error set.
- Latency, with grant rising before edge 1: gS2 valid at edge 2, stable visible after edge 3. Push and CLEAR entry happen at edge 4. outValid and pixClr go high after edge 4. The stored ts is the counter value present in the cycle before edge 4.
- FIFO:
  - Show-ahead: outData always shows the head word while outValid is high.
  - "Full" is count == FIFO_DEPTH and ignores a same-cycle pop, so no push occurs when full even if a pop happens that cycle.
  - A simultaneous push and pop when not full leaves the count unchanged.
  - A pop when empty is ignored.
- Address encoding: index of the single set bit of gS2.
- A grant change during CLEAR does not alter mask.

Decomposition:
- Shared package rdo_pkg holds:
  - the state enum (IDLE, CLEAR, WAIT_REL);
  - localparams for hit-word width (ADDR_W+TS_W) and errCnt width (8);
  - a onehot-check function and a onehot-to-index function.
- One sub-module, hit_fifo: parameterised width and depth, show-ahead, with count, full and empty outputs.

Test Plan:
- Single hit: raise grant[5] and hold; ts=0 at reset -> one word {4'd5, 8'd3}, outValid after edge 4; pixClr[5] high 2 cycles; drop grant 3 cycles later -> busy=0.
- Backpressure: outReady=0, four hits on pixels 1,2,3,4 -> fifoCount=4. A fifth hit on pixel 9 gets no push and no pixClr[9] while grant[9] is held. Set outReady=1 for one cycle -> pixel 9 is captured and fifoCount returns to 4.
- Multi-hot: force grant=16'h0011 stable -> no push; pixClr=16'h0011 for 2 cycles; errMulti=1; errCnt=1.
- Timeout: grant[0] never drops after clear -> errTmo=1 and errCnt increments 16 cycles after pixClr falls; then IDLE. errClr -> all flags 0.
- Glitch: grant pulse of 1 cycle, or alternating values every cycle -> never stable, no push, no pixClr.
- Reset mid-CLEAR: rst_n low while pixClr is high -> pixClr=0 immediately; FIFO empty; timestamp 0.
